// File: rtl/alu_pkg.sv
// Shared encodings for the sequential shift unit: mode codes and FSM states.
package alu_pkg;

  localparam logic [1:0] MODO_LSL = 2'b00;
  localparam logic [1:0] MODO_LSR = 2'b01;
  localparam logic [1:0] MODO_ASR = 2'b10;
  localparam logic [1:0] MODO_ROL = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_shift_step.sv
// Combinational partial shifter: moves val_i by 0..PASO positions in one of four modes.
// ALU_SHIFT_STICKY_EN adds out_or_o, the OR of every bit pushed out of the word.
module alu_shift_step
  import alu_pkg::*;
#(
  parameter int ancho = 4,
  parameter int PASO  = 1,
  localparam int SW   = $clog2(PASO + 1)
) (
  input  logic [ancho-1:0] val_i,
  input  logic [SW-1:0]    amt_i,
  input  logic [1:0]       mode_i,
  input  logic             fill_i,
  output logic [ancho-1:0] res_o,
`ifdef ALU_SHIFT_STICKY_EN
  output logic             out_or_o,
`endif
  output logic             carry_o
);

  logic [ancho-1:0] tmp;
  logic             cy;
  logic             acc;

  // Unrolled single-bit steps; the last bit to leave is the carry.
  always_comb begin
    tmp = val_i;
    cy  = 1'b0;
    acc = 1'b0;
    for (int i = 0; i < PASO; i++) begin
      if (SW'(i) < amt_i) begin
        case (mode_i)
          MODO_LSL: begin
            cy  = tmp[ancho-1];
            tmp = {tmp[ancho-2:0], fill_i};
          end
          MODO_LSR: begin
            cy  = tmp[0];
            tmp = {fill_i, tmp[ancho-1:1]};
          end
          MODO_ASR: begin
            cy  = tmp[0];
            tmp = {tmp[ancho-1], tmp[ancho-1:1]};
          end
          default: begin
            cy  = tmp[ancho-1];
            tmp = {tmp[ancho-2:0], tmp[ancho-1]};
          end
        endcase
        if (mode_i != MODO_ROL) acc = acc | cy;
      end
    end
    res_o   = tmp;
    carry_o = cy;
  end

`ifdef ALU_SHIFT_STICKY_EN
  assign out_or_o = acc;
`endif

endmodule

// File: rtl/alu_shift_seq.sv
// Multi-cycle shift unit: IDLE -> SHIFT (PASO bits per edge) -> DONE with start/busy/done.
// ALU_SHIFT_STICKY_EN builds the sticky accumulator; otherwise sticky is tied low.
module alu_shift_seq
  import alu_pkg::*;
#(
  parameter int ancho = 4,
  parameter int PASO  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [ancho-1:0] a,
  input  logic [ancho-1:0] b,
  input  logic [1:0]       mode,
  input  logic             aluflagin,
  output logic             busy,
  output logic             done,
  output logic [ancho-1:0] aluresult,
  output logic             aluflags,
  output logic             zero,
  output logic             sticky,
  output alu_state_e       state_dbg
);

  localparam int CW = $clog2(ancho + 1);
  localparam int SW = $clog2(PASO + 1);
  localparam logic [ancho-1:0] ANCHO_V = ancho'(ancho);
  localparam logic [CW-1:0]    PASO_C  = CW'(PASO);

  // Handshake: start is taken only in IDLE; busy covers SHIFT; done pulses one cycle in DONE.
  alu_state_e       state_q, state_d;
  logic [CW-1:0]    rem_q, rem_d, n_eff;
  logic [ancho-1:0] val_q, val_d;
  logic [1:0]       mode_q, mode_d;
  logic             fill_q, fill_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic [SW-1:0]    step_amt;
  logic [ancho-1:0] step_res;
  logic             step_carry;

  always_comb begin
    if (mode == MODO_ROL) n_eff = CW'(b % ANCHO_V);
    else if (b >= ANCHO_V) n_eff = CW'(ANCHO_V);
    else n_eff = CW'(b);
  end

  always_comb begin
    if (rem_q > PASO_C) step_amt = SW'(PASO);
    else step_amt = SW'(rem_q);
  end

`ifdef ALU_SHIFT_STICKY_EN
  logic sticky_q, sticky_d, step_or;

  alu_shift_step #(.ancho(ancho), .PASO(PASO)) u_step (
    .val_i(val_q), .amt_i(step_amt), .mode_i(mode_q), .fill_i(fill_q),
    .res_o(step_res), .out_or_o(step_or), .carry_o(step_carry)
  );

  always_comb begin
    sticky_d = sticky_q;
    if (state_q == IDLE && start) sticky_d = 1'b0;
    else if (state_q == SHIFT) sticky_d = sticky_q | step_or;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sticky_q <= 1'b0;
    else sticky_q <= sticky_d;
  end

  assign sticky = sticky_q;
`else
  alu_shift_step #(.ancho(ancho), .PASO(PASO)) u_step (
    .val_i(val_q), .amt_i(step_amt), .mode_i(mode_q), .fill_i(fill_q),
    .res_o(step_res), .carry_o(step_carry)
  );

  assign sticky = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    val_d   = val_q;
    mode_d  = mode_q;
    fill_d  = fill_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          val_d   = a;
          mode_d  = mode;
          fill_d  = aluflagin;
          rem_d   = n_eff;
          carry_d = 1'b0;
          zero_d  = (a == '0);
          state_d = (n_eff == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        val_d   = step_res;
        carry_d = step_carry;
        zero_d  = (step_res == '0);
        rem_d   = rem_q - CW'(step_amt);
        if (rem_q <= PASO_C) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      val_q   <= '0;
      mode_q  <= MODO_LSL;
      fill_q  <= 1'b0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      val_q   <= val_d;
      mode_q  <= mode_d;
      fill_q  <= fill_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end

  assign busy      = (state_q == SHIFT);
  assign done      = (state_q == DONE);
  assign aluresult = val_q;
  assign aluflags  = carry_q;
  assign zero      = zero_q;
  assign state_dbg = state_q;

endmodule
